wb_timer: RTL and testbench

WB_TIMER -- requirements
Module: wb_timer

---
 rtl/wb_timer_if.sv | 25 ++
 rtl/wb_timer.sv | 130 +++++++++++++
 tb/tb_wb_timer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_timer_if.sv
// Pipelined Wishbone bus bundle shared by a master and one slave slot.
// Members: cyc/stb/we/adr/sel/dat_m come from the master; dat_s/ack/stall/err come from the slave.
// No state here; timing and flow control are defined by the endpoints.
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack, stall, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, stall, err
    );
endinterface

// File: rtl/wb_timer.sv
// Machine timer (64-bit mtime/mtimecmp, prescaler, enable) on a pipelined Wishbone slave.
// Latency: ack and read data one cycle after cyc&&stb is sampled; irq_timer registered one cycle.
// Backpressure: none; stall is tied low and a request is accepted every cycle.
// Ports: clk, rst (async active-high), wb (wb_if.slave), irq_timer (level interrupt).
// Register map on adr[11:2]: 0x00/0x04 mtime lo/hi, 0x08/0x0C mtimecmp lo/hi,
// 0x10 prescale, 0x14 ctrl (bit0 enable); other offsets read 0 and ignore writes.
module wb_timer #(
    parameter int prescale_width = 16
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wb,
    output logic irq_timer
);

    localparam logic [9:0] reg_mtime_lo    = 10'd0;
    localparam logic [9:0] reg_mtime_hi    = 10'd1;
    localparam logic [9:0] reg_mtimecmp_lo = 10'd2;
    localparam logic [9:0] reg_mtimecmp_hi = 10'd3;
    localparam logic [9:0] reg_prescale    = 10'd4;
    localparam logic [9:0] reg_ctrl        = 10'd5;

    logic [63:0]               mtime;
    logic [63:0]               mtimecmp;
    logic [prescale_width-1:0] prescale;
    logic [prescale_width-1:0] pcnt;
    logic                      enable;

    logic        req;
    logic        wr;
    logic [9:0]  idx;
    logic        tick;
    logic        pcnt_clr;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp_nxt;
    logic [31:0] rdata;

    // Base address and byte offset within a word are resolved by the interconnect.
    logic unused_adr;
    assign unused_adr = ^{wb.adr[31:12], wb.adr[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign req       = wb.cyc && wb.stb;
    assign wr        = req && wb.we;
    assign idx       = wb.adr[11:2];
    assign wb.stall  = 1'b0;
    assign wb.err    = 1'b0;

    assign tick      = enable && (pcnt == prescale);
    assign mtime_inc = mtime + {63'd0, tick};
    assign pcnt_clr  = wr && ((idx == reg_prescale) || (idx == reg_ctrl));

    // Read value is the pre-update register contents, so a read that lands
    // on a tick returns the pre-tick mtime.
    always_comb begin
        rdata = 32'd0;
        case (idx)
            reg_mtime_lo:    rdata = mtime[31:0];
            reg_mtime_hi:    rdata = mtime[63:32];
            reg_mtimecmp_lo: rdata = mtimecmp[31:0];
            reg_mtimecmp_hi: rdata = mtimecmp[63:32];
            reg_prescale:    rdata = 32'(prescale);
            reg_ctrl:        rdata = {31'd0, enable};
            default:         rdata = 32'd0;
        endcase
    end

    // Written bytes override the incremented mtime; unwritten bytes keep the
    // tick, and the 64-bit add carries lo into hi in the same cycle.
    always_comb begin
        mtime_nxt    = mtime_inc;
        mtimecmp_nxt = mtimecmp;
        if (wr) begin
            case (idx)
                reg_mtime_lo:    mtime_nxt[31:0]     = merge(mtime_inc[31:0], wb.dat_m, wb.sel);
                reg_mtime_hi:    mtime_nxt[63:32]    = merge(mtime_inc[63:32], wb.dat_m, wb.sel);
                reg_mtimecmp_lo: mtimecmp_nxt[31:0]  = merge(mtimecmp[31:0], wb.dat_m, wb.sel);
                reg_mtimecmp_hi: mtimecmp_nxt[63:32] = merge(mtimecmp[63:32], wb.dat_m, wb.sel);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescale  <= '0;
            enable    <= 1'b0;
            pcnt      <= '0;
            wb.ack    <= 1'b0;
            wb.dat_s  <= 32'd0;
            irq_timer <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;

            if (wr && (idx == reg_prescale)) begin
                prescale <= prescale_width'(merge(32'(prescale), wb.dat_m, wb.sel));
            end
            if (wr && (idx == reg_ctrl) && wb.sel[0]) begin
                enable <= wb.dat_m[0];
            end

            // A reprogrammed prescale or ctrl restarts the tick phase.
            if (pcnt_clr || tick) begin
                pcnt <= '0;
            end else if (enable) begin
                pcnt <= pcnt + prescale_width'(1);
            end

            wb.ack   <= req;
            wb.dat_s <= req ? rdata : 32'd0;

            // Compare on current values: irq follows state changes by one cycle.
            irq_timer <= enable && (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: table of bus vectors plus multi-cycle sequences.
// Latency: one bus access spans two clocks (acceptance edge, then ack-drop edge).
// Backpressure: none expected; stall is never consulted.
module tb_wb_timer;

    logic clk = 1'b0;
    logic rst;
    logic irq_timer;

    wb_if wb ();

    wb_timer #(.prescale_width(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (wb),
        .irq_timer (irq_timer)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wb.cyc   = 1'b0;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.adr   = 32'd0;
        wb.sel   = 4'd0;
        wb.dat_m = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One access: accepted on the first edge, ack sampled after it, and
    // ack expected low again after the following edge.
    task automatic bus(input logic we_i, input logic [31:0] adr_i, input logic [3:0] sel_i,
                       input logic [31:0] dat_i, output logic [31:0] rd,
                       output logic ack1, output logic ack2,
                       output logic irq1, output logic irq2);
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = we_i;
        wb.adr   = adr_i;
        wb.sel   = sel_i;
        wb.dat_m = dat_i;
        @(posedge clk);
        #1;
        ack1 = wb.ack;
        rd   = wb.dat_s;
        irq1 = irq_timer;
        idle();
        @(posedge clk);
        #1;
        ack2 = wb.ack;
        irq2 = irq_timer;
    endtask

    task automatic wr(input string name, input logic [31:0] adr_i, input logic [3:0] sel_i,
                      input logic [31:0] dat_i);
        logic [31:0] rd;
        logic a1, a2, i1, i2;
        bus(1'b1, adr_i, sel_i, dat_i, rd, a1, a2, i1, i2);
        check({name, "_ack"}, 64'({a1, a2}), 64'd2);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr_i, input logic [31:0] exp);
        logic [31:0] rd;
        logic a1, a2, i1, i2;
        bus(1'b0, adr_i, 4'hF, 32'd0, rd, a1, a2, i1, i2);
        check({name, "_ack"}, 64'({a1, a2}), 64'd2);
        check(name, 64'(rd), 64'(exp));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic a1, a2, i1, i2;
        int n_ack;
        logic [31:0] b_adr [5];
        logic [31:0] b_dat [5];

        //            we    adr            sel    dat            chk   exp
        vecs[0]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         1'b1, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b0, 32'h0000_000C, 4'hF, 32'h0,         1'b1, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0008, 4'h5, 32'h1122_3344, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         1'b1, 32'hFF22_FF44};
        vecs[8]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b1, 32'h0000_FFFF};
        vecs[10] = '{1'b1, 32'h0000_0018, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0018, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_0004, 4'h8, 32'hAB00_0000, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'h1000_0004, 4'hF, 32'h0,         1'b1, 32'hAB00_0000};
        vecs[16] = '{1'b1, 32'h0000_0014, 4'hF, 32'hFFFF_FFFE, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 32'h0000_0014, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[18] = '{1'b0, 32'h0000_0808, 4'hF, 32'h0,         1'b1, 32'h0};
        vecs[19] = '{1'b1, 32'h0000_000C, 4'h3, 32'h0000_5566, 1'b0, 32'h0};
        vecs[20] = '{1'b0, 32'h0000_000C, 4'hF, 32'h0,         1'b1, 32'hFFFF_5566};

        do_reset();
        check("rst_ack",   64'(wb.ack),    64'd0);
        check("rst_dat_s", 64'(wb.dat_s),  64'd0);
        check("rst_irq",   64'(irq_timer), 64'd0);
        check("rst_stall", 64'(wb.stall),  64'd0);
        check("rst_err",   64'(wb.err),    64'd0);

        // Register access table (enable stays 0, so mtime is static).
        for (int i = 0; i < 21; i++) begin
            bus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, rd, a1, a2, i1, i2);
            check($sformatf("vec%0d_ack", i), 64'({a1, a2}), 64'd2);
            if (vecs[i].chk) check($sformatf("vec%0d_dat", i), 64'(rd), 64'(vecs[i].exp));
            check($sformatf("vec%0d_irq", i), 64'(i2), 64'd0);
        end

        // stb without cyc: no ack, no write.
        wb.cyc = 1'b0; wb.stb = 1'b1; wb.we = 1'b1;
        wb.adr = 32'h14; wb.sel = 4'hF; wb.dat_m = 32'h1;
        @(posedge clk); #1;
        check("nocyc_ack0", 64'(wb.ack), 64'd0);
        idle();
        @(posedge clk); #1;
        check("nocyc_ack1", 64'(wb.ack), 64'd0);
        rd_chk("nocyc_ctrl", 32'h14, 32'h0);

        // Prescale 3: a tick every 4 cycles after the ctrl write edge E0.
        do_reset();
        wr("ps_wr", 32'h10, 4'hF, 32'd3);
        wr("en_wr", 32'h14, 4'hF, 32'd1);
        check("ps_k1", dut.mtime, 64'd0);
        for (int k = 2; k <= 40; k++) begin
            @(posedge clk); #1;
            check($sformatf("ps_k%0d", k), dut.mtime, 64'(k / 4));
        end
        rd_chk("ps_mtime40", 32'h00, 32'd10);

        // Compare at 5: irq one cycle after mtime reaches 5.
        do_reset();
        wr("cmp_lo", 32'h08, 4'hF, 32'd5);
        wr("cmp_hi", 32'h0C, 4'hF, 32'd0);
        wr("cmp_en", 32'h14, 4'hF, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            check($sformatf("cmp_mtime_k%0d", k), dut.mtime, 64'(k));
            check($sformatf("cmp_irq_k%0d", k), 64'(irq_timer), 64'(k >= 6));
        end
        bus(1'b1, 32'h0C, 4'hF, 32'd1, rd, a1, a2, i1, i2);
        check("cmp_hi1_irq_ack", 64'(i1), 64'd1);
        check("cmp_hi1_irq_next", 64'(i2), 64'd0);

        // Carry lo -> hi.
        do_reset();
        wr("cy_lo", 32'h00, 4'hF, 32'hFFFF_FFFF);
        wr("cy_en", 32'h14, 4'hF, 32'd1);
        rd_chk("cy_rd_lo", 32'h00, 32'd0);
        rd_chk("cy_rd_hi", 32'h04, 32'd1);

        // 64-bit wrap drops irq (cmp = all-ones minus 1).
        do_reset();
        wr("wp_lo", 32'h00, 4'hF, 32'hFFFF_FFFD);
        wr("wp_hi", 32'h04, 4'hF, 32'hFFFF_FFFF);
        wr("wp_cmp", 32'h08, 4'hF, 32'hFFFF_FFFE);
        bus(1'b1, 32'h14, 4'hF, 32'd1, rd, a1, a2, i1, i2);
        check("wp_irq0", 64'(i2), 64'd0);
        check("wp_m0", dut.mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk); #1;
        check("wp_m1", dut.mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wp_irq1", 64'(irq_timer), 64'd1);
        @(posedge clk); #1;
        check("wp_m2", dut.mtime, 64'd0);
        check("wp_irq2", 64'(irq_timer), 64'd1);
        @(posedge clk); #1;
        check("wp_m3", dut.mtime, 64'd1);
        check("wp_irq3", 64'(irq_timer), 64'd0);

        // Partial write coinciding with a tick from 0x0000_FFFF; one more
        // tick follows in the ack cycle.
        do_reset();
        wr("pw_lo", 32'h00, 4'hF, 32'h0000_FFFE);
        wr("pw_en", 32'h14, 4'hF, 32'd1);
        check("pw_pre", dut.mtime, 64'h0000_FFFF);
        wr("pw_wr", 32'h00, 4'h3, 32'h0000_1234);
        check("pw_post", dut.mtime, 64'h0001_1235);

        // Eight back-to-back reads.
        do_reset();
        n_ack = 0;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h08; wb.sel = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wb.ack) n_ack++;
            check($sformatf("b2b_dat%0d", i), 64'(wb.dat_s), 64'hFFFF_FFFF);
            if (i == 7) idle();
        end
        @(posedge clk); #1;
        if (wb.ack) n_ack++;
        check("b2b_acks", 64'(n_ack), 64'd8);

        // Write burst interrupted by reset.
        b_adr[0] = 32'h00; b_dat[0] = 32'h0000_AAAA;
        b_adr[1] = 32'h08; b_dat[1] = 32'd5;
        b_adr[2] = 32'h10; b_dat[2] = 32'd7;
        b_adr[3] = 32'h14; b_dat[3] = 32'd1;
        b_adr[4] = 32'h0C; b_dat[4] = 32'd0;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            wb.adr = b_adr[i]; wb.dat_m = b_dat[i];
            @(posedge clk); #1;
        end
        wb.adr = b_adr[3]; wb.dat_m = b_dat[3];
        rst = 1'b1;
        #1;
        check("brst_ack_async", 64'(wb.ack), 64'd0);
        @(posedge clk); #1;
        wb.adr = b_adr[4]; wb.dat_m = b_dat[4];
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb.ack) n_ack++;
        end
        check("brst_no_acks", 64'(n_ack), 64'd0);
        for (int i = 0; i < 6; i++) begin
            rd_chk($sformatf("brst_reg%0d", i), vecs[i].adr, vecs[i].exp);
        end
        check("brst_irq", 64'(irq_timer), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
